// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
//
// General-purpose register file sitting between write-back and decode.
// One synchronous write port (fed by the write-address mux in WB) and two
// combinational read ports (rs, rt) for decode. Entry 0 always reads zero.
// With BYPASS=1 a read of the register being written in the same cycle
// returns the incoming write data, so decode does not need a separate
// WB->ID forwarding path.
//
// Parameters
//   DATA_W  width of each register and of the data ports
//   ADDR_W  address width; depth is 2**ADDR_W
//   BYPASS  1: same-cycle write is visible on reads; 0: reads see storage
//
// Ports
//   Clk      in   1       clock, writes on the rising edge
//   Reset    in   1       asynchronous active-high clear of all entries
//   WrEn     in   1       write enable
//   WrAddr   in   ADDR_W  write destination register
//   WrData   in   DATA_W  write data
//   RdAddr1  in   ADDR_W  read port 1 address (rs)
//   RdAddr2  in   ADDR_W  read port 2 address (rt)
//   RdData1  out  DATA_W  read port 1 data
//   RdData2  out  DATA_W  read port 2 data
//
// There is no state machine and no handshake: the storage array is the only
// state, writes land on the edge after they are presented, reads have zero
// latency.
// ---------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [ADDR_W-1:0] RdAddr1,
  input  logic [ADDR_W-1:0] RdAddr2,
  output logic [DATA_W-1:0] RdData1,
  output logic [DATA_W-1:0] RdData2
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  // A write only counts when it targets a real register; address 0 is
  // excluded so entry 0 keeps the zero it received at reset.
  logic wr_hit;
  assign wr_hit = WrEn && (WrAddr != '0);

  // Reset is tested first so an unknown WrEn while Reset is high cannot
  // reach the array.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_hit) begin
      mem[WrAddr] <= WrData;
    end
  end

  // Read priority: reset, address zero, same-cycle bypass, stored value.
  // The address-zero term sits above the bypass so a discarded write to r0
  // never leaks onto a read port.
  always_comb begin
    RdData1 = mem[RdAddr1];
    if (Reset) begin
      RdData1 = '0;
    end else if (RdAddr1 == '0) begin
      RdData1 = '0;
    end else if (BYP_EN && WrEn && (WrAddr == RdAddr1)) begin
      RdData1 = WrData;
    end
  end

  always_comb begin
    RdData2 = mem[RdAddr2];
    if (Reset) begin
      RdData2 = '0;
    end else if (RdAddr2 == '0) begin
      RdData2 = '0;
    end else if (BYP_EN && WrEn && (WrAddr == RdAddr2)) begin
      RdData2 = WrData;
    end
  end

endmodule
